// File: rtl/combo_load_store_queue_if.sv
// Handshake and bus bundle for the load/store combo: reservation-station enqueue,
// data-cache request/response, and CDB arbitration/broadcast.
interface combo_load_store_queue_if #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RRN_WIDTH = 6
);
  logic                   i_flush;
  logic                   i_valid;
  logic                   o_ready;
  logic                   i_is_store;
  logic [1:0]             i_size;
  logic                   i_sign_ext;
  logic [XLEN-1:0]        i_base;
  logic [XLEN-1:0]        i_immediate;
  logic [XLEN-1:0]        i_store_data;
  logic [RRN_WIDTH-1:0]   i_rrn;
  logic                   o_full;
  logic [$clog2(DEPTH):0] o_count;
  logic                   o_cache_read;
  logic                   o_cache_write;
  logic [XLEN-1:0]        o_cache_address;
  logic [XLEN-1:0]        o_cache_wdata;
  logic [3:0]             o_cache_byte_en;
  logic                   i_cache_hit;
  logic [XLEN-1:0]        i_cache_rdata;
  logic [7:0]             o_arb_address;
  logic                   o_get_bus;
  logic                   i_bus_granted;
  logic                   o_cdb_valid;
  logic [RRN_WIDTH-1:0]   o_cdb_rrn;
  logic [XLEN-1:0]        o_cdb_result;
  logic                   o_cdb_fault;

  // Load/store unit side
  modport slave (
    input  i_flush, i_valid, i_is_store, i_size, i_sign_ext, i_base, i_immediate,
           i_store_data, i_rrn, i_cache_hit, i_cache_rdata, i_bus_granted,
    output o_ready, o_full, o_count, o_cache_read, o_cache_write, o_cache_address,
           o_cache_wdata, o_cache_byte_en, o_arb_address, o_get_bus, o_cdb_valid,
           o_cdb_rrn, o_cdb_result, o_cdb_fault
  );

  // Environment side (reservation station, cache, CDB arbiter)
  modport master (
    output i_flush, i_valid, i_is_store, i_size, i_sign_ext, i_base, i_immediate,
           i_store_data, i_rrn, i_cache_hit, i_cache_rdata, i_bus_granted,
    input  o_ready, o_full, o_count, o_cache_read, o_cache_write, o_cache_address,
           o_cache_wdata, o_cache_byte_en, o_arb_address, o_get_bus, o_cdb_valid,
           o_cdb_rrn, o_cdb_result, o_cdb_fault
  );
endinterface

// File: rtl/combo_load_store_queue.sv
// In-order load/store queue: enqueue with EA calculation, one cache access at a time,
// then CDB arbitration and a single-cycle tagged broadcast.
module combo_load_store_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned RRN_WIDTH       = 6,
  parameter logic [7:0]  ARBITER_ADDRESS = 8'h00
) (
  input logic                      i_clock,
  input logic                      i_reset,
  combo_load_store_queue_if.slave  io_lsq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                 is_store;
    logic [1:0]           size;
    logic                 sign_ext;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      data;
    logic [RRN_WIDTH-1:0] rrn;
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_BUS, S_BCAST} state_t;

  op_t                  r_queue [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  state_t               r_state;
  state_t               w_state_next;
  op_t                  r_work;
  logic                 r_work_fault;
  logic [XLEN-1:0]      r_work_result;
  logic                 r_drop;

  op_t                  w_new_op;
  op_t                  w_head;
  logic                 w_full;
  logic                 w_enq;
  logic                 w_pop;
  logic                 w_head_misaligned;
  logic [4:0]           w_lane_shift;
  logic [XLEN-1:0]      w_lane;
  logic [XLEN-1:0]      w_load_value;
  logic [3:0]           w_byte_en;

  logic                 w_cache_read;
  logic                 w_cache_write;
  logic [XLEN-1:0]      w_cache_address;
  logic [XLEN-1:0]      w_cache_wdata;
  logic [3:0]           w_cache_byte_en;
  logic                 w_get_bus;
  logic                 w_cdb_valid;
  logic [RRN_WIDTH-1:0] w_cdb_rrn;
  logic [XLEN-1:0]      w_cdb_result;
  logic                 w_cdb_fault;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_enq  = io_lsq.i_valid && !w_full && !io_lsq.i_flush;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !io_lsq.i_flush;
  assign w_head = r_queue[r_head];

  // Effective address is formed once at enqueue and carried with the op
  always_comb begin
    w_new_op          = '0;
    w_new_op.is_store = io_lsq.i_is_store;
    w_new_op.size     = io_lsq.i_size;
    w_new_op.sign_ext = io_lsq.i_sign_ext;
    w_new_op.addr     = io_lsq.i_base + io_lsq.i_immediate;
    w_new_op.data     = io_lsq.i_store_data;
    w_new_op.rrn      = io_lsq.i_rrn;
  end

  assign w_head_misaligned = ((w_head.size == 2'd1) && w_head.addr[0]) ||
                             (w_head.size[1] && (w_head.addr[1:0] != 2'b00));

  always_ff @(posedge i_clock) begin
    if (w_enq) begin
      r_queue[r_tail] <= w_new_op;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (io_lsq.i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
    end
  end

  // Load lane select and extension
  assign w_lane_shift = {r_work.addr[1:0], 3'b000};
  assign w_lane       = io_lsq.i_cache_rdata >> w_lane_shift;

  always_comb begin
    w_load_value = w_lane;
    case (r_work.size)
      2'd0: w_load_value = r_work.sign_ext ? {{(XLEN-8){w_lane[7]}}, w_lane[7:0]}
                                           : XLEN'(w_lane[7:0]);
      2'd1: w_load_value = r_work.sign_ext ? {{(XLEN-16){w_lane[15]}}, w_lane[15:0]}
                                           : XLEN'(w_lane[15:0]);
      default: w_load_value = w_lane;
    endcase
  end

  always_comb begin
    w_byte_en = 4'hF;
    case (r_work.size)
      2'd0:    w_byte_en = 4'b0001 << r_work.addr[1:0];
      2'd1:    w_byte_en = 4'b0011 << r_work.addr[1:0];
      default: w_byte_en = 4'hF;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An issued store caught by flush keeps its write pending; r_drop suppresses its broadcast
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_next = w_head_misaligned ? S_BUS : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (io_lsq.i_cache_hit) begin
          w_state_next = (r_drop || io_lsq.i_flush) ? S_IDLE : S_BUS;
        end else if (io_lsq.i_flush && !r_work.is_store) begin
          w_state_next = S_IDLE;
        end
      end
      S_BUS: begin
        if (io_lsq.i_flush) begin
          w_state_next = S_IDLE;
        end else if (io_lsq.i_bus_granted) begin
          w_state_next = S_BCAST;
        end
      end
      S_BCAST: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cache_read    = 1'b0;
    w_cache_write   = 1'b0;
    w_cache_address = '0;
    w_cache_wdata   = '0;
    w_cache_byte_en = '0;
    w_get_bus       = 1'b0;
    w_cdb_valid     = 1'b0;
    w_cdb_rrn       = '0;
    w_cdb_result    = '0;
    w_cdb_fault     = 1'b0;
    case (r_state)
      S_ACCESS: begin
        w_cache_read    = !r_work.is_store;
        w_cache_write   = r_work.is_store;
        w_cache_address = {r_work.addr[XLEN-1:2], 2'b00};
        w_cache_wdata   = r_work.data << w_lane_shift;
        w_cache_byte_en = w_byte_en;
      end
      S_BUS: w_get_bus = 1'b1;
      S_BCAST: begin
        w_cdb_valid  = 1'b1;
        w_cdb_rrn    = r_work.rrn;
        w_cdb_result = r_work_result;
        w_cdb_fault  = r_work_fault;
      end
      default: ;
    endcase
  end

  // Working register: popped head plus the captured result
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_work        <= '0;
      r_work_fault  <= 1'b0;
      r_work_result <= '0;
      r_drop        <= 1'b0;
    end else begin
      if (w_pop) begin
        r_work        <= w_head;
        r_work_fault  <= w_head_misaligned;
        r_work_result <= '0;
      end else if ((r_state == S_ACCESS) && io_lsq.i_cache_hit) begin
        r_work_result <= r_work.is_store ? '0 : w_load_value;
      end
      if ((r_state == S_ACCESS) && r_work.is_store && io_lsq.i_flush && !io_lsq.i_cache_hit) begin
        r_drop <= 1'b1;
      end else if (w_state_next != S_ACCESS) begin
        r_drop <= 1'b0;
      end
    end
  end

  assign io_lsq.o_full          = w_full;
  assign io_lsq.o_ready         = !w_full;
  assign io_lsq.o_count         = r_count;
  assign io_lsq.o_arb_address   = ARBITER_ADDRESS;
  assign io_lsq.o_cache_read    = w_cache_read;
  assign io_lsq.o_cache_write   = w_cache_write;
  assign io_lsq.o_cache_address = w_cache_address;
  assign io_lsq.o_cache_wdata   = w_cache_wdata;
  assign io_lsq.o_cache_byte_en = w_cache_byte_en;
  assign io_lsq.o_get_bus       = w_get_bus;
  assign io_lsq.o_cdb_valid     = w_cdb_valid;
  assign io_lsq.o_cdb_rrn       = w_cdb_rrn;
  assign io_lsq.o_cdb_result    = w_cdb_result;
  assign io_lsq.o_cdb_fault     = w_cdb_fault;
endmodule

// File: tb/tb_combo_load_store_queue.sv
// Directed bench for combo_load_store_queue with hand-computed expectations.
module tb_combo_load_store_queue;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   bad;
  int   nb;
  logic [31:0] exp_res [9];

  combo_load_store_queue_if #(.DEPTH(8), .XLEN(32), .RRN_WIDTH(6)) lsq_if ();

  combo_load_store_queue #(
    .DEPTH(8), .XLEN(32), .RRN_WIDTH(6), .ARBITER_ADDRESS(8'hA5)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_lsq  (lsq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] data, input logic [5:0] rrn);
    lsq_if.i_is_store   = st;
    lsq_if.i_size       = sz;
    lsq_if.i_sign_ext   = sx;
    lsq_if.i_base       = base;
    lsq_if.i_immediate  = imm;
    lsq_if.i_store_data = data;
    lsq_if.i_rrn        = rrn;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    lsq_if.i_flush       = 1'b0;
    lsq_if.i_valid       = 1'b0;
    lsq_if.i_cache_hit   = 1'b0;
    lsq_if.i_cache_rdata = '0;
    lsq_if.i_bus_granted = 1'b0;
    set_op(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 6'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready",   32'(lsq_if.o_ready), 32'd1);
    chk("rst_full",    32'(lsq_if.o_full), 32'd0);
    chk("rst_count",   32'(lsq_if.o_count), 32'd0);
    chk("rst_read",    32'(lsq_if.o_cache_read), 32'd0);
    chk("rst_write",   32'(lsq_if.o_cache_write), 32'd0);
    chk("rst_get_bus", 32'(lsq_if.o_get_bus), 32'd0);
    chk("rst_cdb_vld", 32'(lsq_if.o_cdb_valid), 32'd0);
    chk("rst_arb",     32'(lsq_if.o_arb_address), 32'hA5);

    // Signed byte load from lane 3, immediate hit and grant
    lsq_if.i_cache_hit   = 1'b1;
    lsq_if.i_bus_granted = 1'b1;
    lsq_if.i_cache_rdata = 32'h8000_0000;
    set_op(1'b0, 2'd0, 1'b1, 32'h1000, 32'h3, 32'h0, 6'd1);
    lsq_if.i_valid = 1'b1;
    step();
    lsq_if.i_valid = 1'b0;
    step();
    chk("t1_read", 32'(lsq_if.o_cache_read), 32'd1);
    chk("t1_addr", lsq_if.o_cache_address, 32'h1000);
    chk("t1_be",   32'(lsq_if.o_cache_byte_en), 32'h8);
    step();
    chk("t1_early_vld", 32'(lsq_if.o_cdb_valid), 32'd0);
    step();
    chk("t1_vld",    32'(lsq_if.o_cdb_valid), 32'd1);
    chk("t1_result", lsq_if.o_cdb_result, 32'hFFFF_FF80);
    chk("t1_rrn",    32'(lsq_if.o_cdb_rrn), 32'd1);
    chk("t1_fault",  32'(lsq_if.o_cdb_fault), 32'd0);
    step();
    chk("t1_pulse",  32'(lsq_if.o_cdb_valid), 32'd0);

    // Half store to upper half of word
    set_op(1'b1, 2'd1, 1'b0, 32'h2000, 32'h2, 32'h0000_BEEF, 6'd2);
    lsq_if.i_valid = 1'b1;
    step();
    lsq_if.i_valid = 1'b0;
    step();
    chk("t2_write", 32'(lsq_if.o_cache_write), 32'd1);
    chk("t2_read",  32'(lsq_if.o_cache_read), 32'd0);
    chk("t2_addr",  lsq_if.o_cache_address, 32'h2000);
    chk("t2_be",    32'(lsq_if.o_cache_byte_en), 32'hC);
    chk("t2_wdata", lsq_if.o_cache_wdata, 32'hBEEF_0000);
    step();
    step();
    chk("t2_vld",    32'(lsq_if.o_cdb_valid), 32'd1);
    chk("t2_result", lsq_if.o_cdb_result, 32'h0);
    chk("t2_fault",  32'(lsq_if.o_cdb_fault), 32'd0);
    chk("t2_rrn",    32'(lsq_if.o_cdb_rrn), 32'd2);
    step();

    // Misaligned word load skips the cache
    set_op(1'b0, 2'd2, 1'b0, 32'h3000, 32'h1, 32'h0, 6'd3);
    lsq_if.i_valid = 1'b1;
    step();
    lsq_if.i_valid = 1'b0;
    step();
    chk("t3_read",    32'(lsq_if.o_cache_read), 32'd0);
    chk("t3_write",   32'(lsq_if.o_cache_write), 32'd0);
    chk("t3_get_bus", 32'(lsq_if.o_get_bus), 32'd1);
    step();
    chk("t3_vld",    32'(lsq_if.o_cdb_valid), 32'd1);
    chk("t3_fault",  32'(lsq_if.o_cdb_fault), 32'd1);
    chk("t3_result", lsq_if.o_cdb_result, 32'h0);
    chk("t3_rrn",    32'(lsq_if.o_cdb_rrn), 32'd3);
    step();

    // Fill the queue behind a stalled miss; the ninth push lands in the last slot
    lsq_if.i_cache_hit   = 1'b0;
    lsq_if.i_cache_rdata = 32'h4433_2211;
    exp_res = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11};
    for (int k = 0; k < 9; k++) begin
      set_op(1'b0, 2'd0, 1'b0, 32'h4000, 32'(k), 32'h0, 6'(10 + k));
      lsq_if.i_valid = 1'b1;
      step();
    end
    set_op(1'b0, 2'd0, 1'b0, 32'h4000, 32'h0, 32'h0, 6'd19);
    step();
    lsq_if.i_valid = 1'b0;
    chk("t4_full",  32'(lsq_if.o_full), 32'd1);
    chk("t4_ready", 32'(lsq_if.o_ready), 32'd0);
    chk("t4_count", 32'(lsq_if.o_count), 32'd8);
    chk("t4_stall", 32'(lsq_if.o_cache_read), 32'd1);
    lsq_if.i_cache_hit = 1'b1;
    nb = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (lsq_if.o_cdb_valid === 1'b1) begin
        if (nb < 9) begin
          chk("t4_rrn", 32'(lsq_if.o_cdb_rrn), 32'(10 + nb));
          chk("t4_res", lsq_if.o_cdb_result, exp_res[nb]);
        end
        nb++;
      end
    end
    chk("t4_bcasts", 32'(nb), 32'd9);
    chk("t4_empty",  32'(lsq_if.o_count), 32'd0);

    // Grant withheld for 10 cycles
    lsq_if.i_bus_granted = 1'b0;
    lsq_if.i_cache_rdata = 32'h1234_5678;
    set_op(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h0, 6'd20);
    lsq_if.i_valid = 1'b1;
    step();
    lsq_if.i_valid = 1'b0;
    step();
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (lsq_if.o_get_bus !== 1'b1 || lsq_if.o_cdb_valid !== 1'b0) bad++;
      step();
    end
    chk("t5_hold", 32'(bad), 32'd0);
    lsq_if.i_bus_granted = 1'b1;
    step();
    lsq_if.i_bus_granted = 1'b0;
    chk("t5_vld",     32'(lsq_if.o_cdb_valid), 32'd1);
    chk("t5_get_bus", 32'(lsq_if.o_get_bus), 32'd0);
    chk("t5_result",  lsq_if.o_cdb_result, 32'h1234_5678);
    chk("t5_rrn",     32'(lsq_if.o_cdb_rrn), 32'd20);
    step();
    chk("t5_pulse",   32'(lsq_if.o_cdb_valid), 32'd0);

    // Flush with a store mid-access and three queued loads
    lsq_if.i_cache_hit   = 1'b0;
    lsq_if.i_bus_granted = 1'b1;
    set_op(1'b1, 2'd2, 1'b0, 32'h6000, 32'h0, 32'hCAFE_F00D, 6'd30);
    lsq_if.i_valid = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      set_op(1'b0, 2'd2, 1'b0, 32'h6100, 32'(4 * k), 32'h0, 6'(31 + k));
      step();
    end
    chk("t6_count", 32'(lsq_if.o_count), 32'd3);
    chk("t6_write", 32'(lsq_if.o_cache_write), 32'd1);
    chk("t6_addr",  lsq_if.o_cache_address, 32'h6000);
    chk("t6_wdata", lsq_if.o_cache_wdata, 32'hCAFE_F00D);
    set_op(1'b0, 2'd2, 1'b0, 32'h6200, 32'h0, 32'h0, 6'd40);
    lsq_if.i_flush = 1'b1;
    step();
    lsq_if.i_flush = 1'b0;
    lsq_if.i_valid = 1'b0;
    chk("t6_count_flush", 32'(lsq_if.o_count), 32'd0);
    chk("t6_write_held",  32'(lsq_if.o_cache_write), 32'd1);
    chk("t6_addr_held",   lsq_if.o_cache_address, 32'h6000);
    lsq_if.i_cache_hit = 1'b1;
    step();
    lsq_if.i_cache_hit = 1'b0;
    chk("t6_write_done", 32'(lsq_if.o_cache_write), 32'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (lsq_if.o_cdb_valid !== 1'b0 || lsq_if.o_get_bus !== 1'b0 ||
          lsq_if.o_cache_read !== 1'b0 || lsq_if.o_cache_write !== 1'b0 ||
          lsq_if.o_count !== '0) bad++;
    end
    chk("t6_quiet", 32'(bad), 32'd0);

    // Asynchronous reset drops an outstanding read without a clock edge
    set_op(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 32'h0, 6'd5);
    lsq_if.i_valid = 1'b1;
    step();
    lsq_if.i_valid = 1'b0;
    step();
    chk("t7_read", 32'(lsq_if.o_cache_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_read_async", 32'(lsq_if.o_cache_read), 32'd0);
    chk("t7_ready",      32'(lsq_if.o_ready), 32'd1);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/combo_load_store_queue.md
Name: combo_load_store_queue

Overview:
Parametrised next-generation load/store combo. Accepts decoded memory ops from the LS reservation station into an in-order queue and computes the effective address. It drives the data cache one request at a time, waiting through misses. It then arbitrates for the CDB and broadcasts the load result or store completion tagged with the op's RRN. Adds over the previous combo: configurable depth and widths, sub-word access with byte enables and sign extension, a misalignment fault, and flush.

Parameters:
DEPTH, 8, queue entries (power of two, ≥2)
XLEN, 32, data/address width
RRN_WIDTH, 6, rename register tag width
ARBITER_ADDRESS, 8'h00, CDB arbiter slot identifier, driven on o_arb_address

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous active-high reset
i_flush  in  1  synchronous pipeline flush
i_valid  in  1  new op present
o_ready  out  1  queue can accept (= !o_full)
i_is_store  in  1  1=store, 0=load
i_size  in  2  0=byte, 1=half, 2=word
i_sign_ext  in  1  loads: sign-extend sub-word
i_base  in  XLEN  rs1 value
i_immediate  in  XLEN  offset
i_store_data  in  XLEN  rs2 value
i_rrn  in  RRN_WIDTH  destination tag
o_full  out  1  count==DEPTH
o_count  out  $clog2(DEPTH)+1  occupied entries
o_cache_read  out  1  read request
o_cache_write  out  1  write request
o_cache_address  out  XLEN  word-aligned address (low 2 bits zero)
o_cache_wdata  out  XLEN  lane-shifted store data
o_cache_byte_en  out  4  byte lanes
i_cache_hit  in  1  access complete this cycle
i_cache_rdata  in  XLEN  read word, valid with hit
o_arb_address  out  8  = ARBITER_ADDRESS
o_get_bus  out  1  CDB request
i_bus_granted  in  1  grant, one cycle
o_cdb_valid  out  1  broadcast strobe
o_cdb_rrn  out  RRN_WIDTH  tag
o_cdb_result  out  XLEN  load data (0 for stores)
o_cdb_fault  out  1  misaligned access

Behaviour:
- Reset: all outputs 0 except o_ready=1 and o_arb_address=ARBITER_ADDRESS; queue empty; FSM=IDLE.
- Enqueue when i_valid&&o_ready. Effective address = i_base+i_immediate, computed at enqueue and stored, modulo 2^XLEN. Pointers wrap modulo DEPTH.
- Simultaneous enqueue and dequeue at full is not allowed: o_ready reflects current count only.
- FSM IDLE: if queue non-empty, go to ACCESS next cycle and pop the head into the working register.
- Misaligned head (half with addr[0]=1; word with addr[1:0]!=0) skips ACCESS and goes directly to BUS with fault=1, result=0. No cache request is issued.
- ACCESS: assert exactly one of read/write plus address/wdata/byte_en, held stable until i_cache_hit.
  - On hit, load data is selected from lane addr[1:0], then zero- or sign-extended.
  - Then go to BUS.
  - Miss (hit low) holds indefinitely.
- BUS: assert o_get_bus. In the cycle after i_bus_granted, pulse o_cdb_valid for exactly 1 cycle with rrn/result/fault, and drop o_get_bus. Return to IDLE.
- Latency:
  - Enqueue to ACCESS: ≥1 cycle.
  - Minimum end-to-end with immediate hit and grant: 4 cycles from enqueue to o_cdb_valid.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 3<<addr[1:0]
  - word: 4'hF
  - wdata is shifted left by 8*addr[1:0].
- i_flush: empties the queue and forces IDLE next cycle, except an ACCESS store that has been issued but not yet hit completes its cache write, then drops its CDB broadcast. A flush in the same cycle as i_valid discards the new op.
- i_reset mid-access deasserts cache requests immediately (async).

Test Plan:
- Load byte 0x80 at addr 0x1003, sign_ext=1, immediate hit/grant -> byte_en=4'b1000, o_cdb_result=0xFFFFFF80, o_cdb_valid 4 cycles after enqueue.
- Store half 0xBEEF, base 0x2000, imm 2 -> o_cache_address=0x2000, byte_en=4'b1100, wdata=0xBEEF0000; CDB result 0, fault 0.
- Word load at 0x3001 -> no cache request; o_cdb_fault=1 after grant.
- Fill DEPTH ops while hit is held low -> o_full=1, o_ready=0, o_count=DEPTH. Release hit -> results broadcast in issue order with correct RRNs.
- Grant withheld 10 cycles -> o_get_bus held high, o_cdb_valid stays 0, then a single pulse one cycle after grant.
- Flush with 3 queued ops and a store mid-access -> write completes, no CDB pulse, o_count=0.
